// File: rtl/superbug_pkg.sv
// Shared types and constants for the superbug ROM download path.
package superbug_pkg;

  localparam int unsigned ROM_ADDR_W   = 17;
  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BYTE_COUNT_W = 18;
  localparam int unsigned REGION_W     = 4;

  // Default ROM map: region 0 starts at 0, region 3 ends at TOTAL_BYTES-1.
  localparam int unsigned DEF_REGION1_BASE  = 32'h3000;
  localparam int unsigned DEF_REGION2_BASE  = 32'h3800;
  localparam int unsigned DEF_REGION3_BASE  = 32'h4000;
  localparam int unsigned DEF_TOTAL_BYTES   = 32'h4800;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;

  localparam logic [REGION_W-1:0] REGION_0 = 4'b0001;
  localparam logic [REGION_W-1:0] REGION_1 = 4'b0010;
  localparam logic [REGION_W-1:0] REGION_2 = 4'b0100;
  localparam logic [REGION_W-1:0] REGION_3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] addr;
    logic [BYTE_W-1:0]     data;
  } dn_bus_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational byte address to one-hot ROM region plus in-range flag.
module rom_region_decode
  import superbug_pkg::*;
#(
  parameter int unsigned REGION1_BASE = DEF_REGION1_BASE,
  parameter int unsigned REGION2_BASE = DEF_REGION2_BASE,
  parameter int unsigned REGION3_BASE = DEF_REGION3_BASE,
  parameter int unsigned TOTAL_BYTES  = DEF_TOTAL_BYTES
) (
  input  logic [IOCTL_ADDR_W-1:0] addr,
  output logic [REGION_W-1:0]     region_c,
  output logic                    in_range_c
);

  localparam logic [IOCTL_ADDR_W-1:0] R1 = IOCTL_ADDR_W'(REGION1_BASE);
  localparam logic [IOCTL_ADDR_W-1:0] R2 = IOCTL_ADDR_W'(REGION2_BASE);
  localparam logic [IOCTL_ADDR_W-1:0] R3 = IOCTL_ADDR_W'(REGION3_BASE);
  localparam logic [IOCTL_ADDR_W-1:0] RE = IOCTL_ADDR_W'(TOTAL_BYTES);

  // Full-width compares so stray upper address bits never alias into a region.
  always_comb begin
    region_c = REGION_3;
    if (addr < R1) begin
      region_c = REGION_0;
    end else if (addr < R2) begin
      region_c = REGION_1;
    end else if (addr < R3) begin
      region_c = REGION_2;
    end
  end

  assign in_range_c = (addr < RE);

endmodule

// File: rtl/rom_load_sequencer.sv
// Sequences the HPS ioctl ROM download into the core's dn_* port and
// holds the core in reset through the download and a settle period.
module rom_load_sequencer
  import superbug_pkg::*;
#(
  parameter int unsigned REGION1_BASE  = DEF_REGION1_BASE,
  parameter int unsigned REGION2_BASE  = DEF_REGION2_BASE,
  parameter int unsigned REGION3_BASE  = DEF_REGION3_BASE,
  parameter int unsigned TOTAL_BYTES   = DEF_TOTAL_BYTES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [BYTE_W-1:0]       ioctl_dout,
  input  logic                    rst_req,
  output logic [ROM_ADDR_W-1:0]   dn_addr,
  output logic [BYTE_W-1:0]       dn_data,
  output logic                    dn_wr,
  output logic [REGION_W-1:0]     region_sel,
  output logic                    core_reset_n,
  output logic                    load_done,
  output logic                    load_error,
  output logic [BYTE_COUNT_W-1:0] byte_count
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]     SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [BYTE_COUNT_W-1:0] COUNT_MAX   = '1;
  localparam logic [BYTE_COUNT_W-1:0] COUNT_FULL  = BYTE_COUNT_W'(TOTAL_BYTES);

  seq_state_e                state_q, state_d;
  dn_bus_t                   dn_q, dn_d;
  logic                      dn_wr_d;
  logic [REGION_W-1:0]       region_sel_d;
  logic                      load_done_d;
  logic                      load_error_d;
  logic [BYTE_COUNT_W-1:0]   byte_count_d;
  logic                      overflow_q, overflow_d;
  logic [SETTLE_W-1:0]       settle_q, settle_d;
  logic                      start_load;
  logic [REGION_W-1:0]       dec_region;
  logic                      dec_in_range;

  rom_region_decode #(
    .REGION1_BASE (REGION1_BASE),
    .REGION2_BASE (REGION2_BASE),
    .REGION3_BASE (REGION3_BASE),
    .TOTAL_BYTES  (TOTAL_BYTES)
  ) u_decode (
    .addr       (ioctl_addr),
    .region_c   (dec_region),
    .in_range_c (dec_in_range)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    dn_d         = dn_q;
    dn_wr_d      = 1'b0;
    region_sel_d = '0;
    load_done_d  = load_done;
    load_error_d = load_error;
    byte_count_d = byte_count;
    overflow_d   = overflow_q;
    settle_d     = settle_q;
    start_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ioctl_download) begin
          start_load = 1'b1;
        end
      end

      LOAD: begin
        // A strobe coincident with download falling is still taken.
        if (ioctl_wr) begin
          if (dec_in_range) begin
            dn_wr_d      = 1'b1;
            dn_d.addr    = ioctl_addr[ROM_ADDR_W-1:0];
            dn_d.data    = ioctl_dout;
            region_sel_d = dec_region;
            if (byte_count != COUNT_MAX) begin
              byte_count_d = byte_count + BYTE_COUNT_W'(1);
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!ioctl_download) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        if (ioctl_download) begin
          start_load = 1'b1;
        end else if (settle_q == '0) begin
          state_d      = RUN;
          load_done_d  = 1'b1;
          load_error_d = (byte_count != COUNT_FULL) | overflow_q;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end

      RUN: begin
        if (ioctl_download) begin
          start_load = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every new download starts from clean counters and flags.
    if (start_load) begin
      state_d      = LOAD;
      byte_count_d = '0;
      overflow_d   = 1'b0;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      dn_q       <= '0;
      dn_wr      <= 1'b0;
      region_sel <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      byte_count <= '0;
      overflow_q <= 1'b0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      dn_q       <= dn_d;
      dn_wr      <= dn_wr_d;
      region_sel <= region_sel_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;
      byte_count <= byte_count_d;
      overflow_q <= overflow_d;
      settle_q   <= settle_d;
    end
  end

  assign dn_addr = dn_q.addr;
  assign dn_data = dn_q.data;

  // Combinational so a run-time reset request reaches the core in the same cycle.
  assign core_reset_n = (state_q == RUN) & ~rst_req;

endmodule
